// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder.
// Holds the RV32 FUNC3 load/store size encodings and the responder FSM
// state type used by the top level.
package data_mem_responder_pkg;

    // Load size / extension encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store size encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_lane_align.sv
// Combinational byte-lane alignment for the data-memory responder.
// Ports:
//   word       - 32-bit word read from the array
//   offset     - byte offset within the word (ADDRESS[1:0])
//   func3      - access size / extension select
//   store_in   - raw store data from the pipeline (lanes taken from low bits)
//   load_value - selected lane, sign- or zero-extended to 32 bits
//   byte_en    - byte-lane write enables for a store
//   store_word - store data replicated so every enabled lane sees its byte
module data_mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  func3,
    input  logic [31:0] store_in,
    output logic [31:0] load_value,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        case (offset)
            2'd0:    lane_byte = word[7:0];
            2'd1:    lane_byte = word[15:8];
            2'd2:    lane_byte = word[23:16];
            default: lane_byte = word[31:24];
        endcase
        // Half accesses ignore offset[0]
        lane_half = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        case (func3)
            F3_LB:   load_value = {{24{lane_byte[7]}}, lane_byte};
            F3_LH:   load_value = {{16{lane_half[15]}}, lane_half};
            F3_LW:   load_value = word;
            F3_LBU:  load_value = {24'd0, lane_byte};
            F3_LHU:  load_value = {16'd0, lane_half};
            default: load_value = word;
        endcase
    end

    // Data is replicated across lanes so the enables alone pick the target
    always_comb begin
        case (func3)
            F3_SB: begin
                byte_en    = 4'b0001 << offset;
                store_word = {4{store_in[7:0]}};
            end
            F3_SH: begin
                byte_en    = offset[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_in[15:0]}};
            end
            F3_SW: begin
                byte_en    = 4'b1111;
                store_word = store_in;
            end
            default: begin
                byte_en    = 4'b1111;
                store_word = store_in;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage of the pipelined RV32 core.
// Accepts a load/store from the MEM stage, stalls the pipeline for a fixed
// LATENCY, then performs the access on the word-organised array.
// Ports:
//   CLK        - clock, all state changes on posedge
//   RESET      - synchronous active-high reset
//   ADDRESS    - byte address (upper bits beyond the array wrap)
//   WRITE_DATA - store data, lanes from the low bits
//   READ/WRITE - load / store request (WRITE wins when both high)
//   FUNC3      - access size and extension select
//   READ_DATA  - registered, extended load result
//   BUSY_WAIT  - pipeline stall while a request is pending
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [2:0]  FUNC3,
    output logic [31:0] READ_DATA,
    output logic        BUSY_WAIT
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    state_t state, state_next;

    logic [3:0]       count;
    logic [IDX_W+1:0] addr_q;
    logic [31:0]      wdata_q;
    logic [2:0]       func3_q;
    logic             write_q;
    logic             req;
    logic             access_now;
    logic [IDX_W-1:0] idx;
    logic [31:0]      word_rd;
    logic [31:0]      load_value;
    logic [31:0]      store_word;
    logic [3:0]       byte_en;

    logic [31:0] mem [DEPTH_WORDS];

    // Address bits above the array are deliberately ignored (wrap-around)
    logic unused_addr_hi;
    assign unused_addr_hi = ^ADDRESS[31:IDX_W+2];

    assign req     = READ | WRITE;
    assign idx     = addr_q[IDX_W+1:2];
    assign word_rd = mem[idx];

    data_mem_lane_align u_align (
        .word       (word_rd),
        .offset     (addr_q[1:0]),
        .func3      (func3_q),
        .store_in   (wdata_q),
        .load_value (load_value),
        .byte_en    (byte_en),
        .store_word (store_word)
    );

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        BUSY_WAIT  = 1'b0;
        access_now = 1'b0;
        case (state)
            IDLE: begin
                BUSY_WAIT = req;
                if (req) state_next = ACCESS;
            end
            ACCESS: begin
                BUSY_WAIT = 1'b1;
                if (!req) begin
                    state_next = IDLE;
                end else if (count == '0) begin
                    access_now = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count     <= '0;
            READ_DATA <= '0;
        end else begin
            if (state == IDLE && req) begin
                addr_q  <= ADDRESS[IDX_W+1:0];
                wdata_q <= WRITE_DATA;
                func3_q <= FUNC3;
                write_q <= WRITE;
                count   <= 4'(LATENCY - 1);
            end else if (state == ACCESS && req && count != '0) begin
                count <= count - 4'd1;
            end
            if (access_now && !write_q) READ_DATA <= load_value;
        end
    end

    // Array is not cleared by reset; reset only suppresses a pending write
    always_ff @(posedge CLK) begin
        if (!RESET && access_now && write_q) begin
            for (int unsigned lane = 0; lane < 4; lane++) begin
                if (byte_en[lane]) mem[idx][lane*8 +: 8] <= store_word[lane*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic        READ;
    logic        WRITE;
    logic [2:0]  FUNC3;
    logic [31:0] READ_DATA;
    logic        BUSY_WAIT;

    int checks   = 0;
    int failures = 0;

    bit [31:0] mem_model [DEPTH];
    bit [31:0] rd_model;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ADDRESS    (ADDRESS),
        .WRITE_DATA (WRITE_DATA),
        .READ       (READ),
        .WRITE      (WRITE),
        .FUNC3      (FUNC3),
        .READ_DATA  (READ_DATA),
        .BUSY_WAIT  (BUSY_WAIT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] ref_load(input bit [31:0] w, input bit [31:0] a, input bit [2:0] f3);
        bit [31:0] b, h;
        b = (w >> ((a % 4) * 8)) & 32'hFF;
        h = (w >> (((a / 2) % 2) * 16)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
            3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic bit [31:0] ref_store(input bit [31:0] old, input bit [31:0] a,
                                            input bit [31:0] d, input bit [2:0] f3);
        bit [31:0] mask;
        int unsigned sh;
        case (f3)
            3'd0: begin sh = (a % 4) * 8;       mask = 32'hFF << sh;   end
            3'd1: begin sh = ((a / 2) % 2) * 16; mask = 32'hFFFF << sh; end
            default: return d;
        endcase
        return (old & ~mask) | ((d << sh) & mask);
    endfunction

    // Starts one cycle after a posedge with the FSM in IDLE; returns likewise.
    // abort_at >= 0 drops the request in that ACCESS cycle.
    task automatic run_req(input bit rd, input bit wr, input bit [31:0] addr,
                           input bit [31:0] wdata, input bit [2:0] f3,
                           input int abort_at, output logic [31:0] obs);
        int unsigned widx;
        READ = rd; WRITE = wr; ADDRESS = addr; WRITE_DATA = wdata; FUNC3 = f3;
        @(negedge CLK);
        check("req_busy", {31'd0, BUSY_WAIT}, 32'd1);
        check("req_rd_hold", READ_DATA, rd_model);
        @(posedge CLK); #1;
        // Changing request fields mid-access must not matter
        ADDRESS = $urandom; WRITE_DATA = $urandom; FUNC3 = 3'($urandom);
        for (int c = 0; c < int'(LAT); c++) begin
            if (c == abort_at) begin READ = 1'b0; WRITE = 1'b0; end
            @(negedge CLK);
            check("access_busy", {31'd0, BUSY_WAIT}, 32'd1);
            check("access_rd_hold", READ_DATA, rd_model);
            @(posedge CLK); #1;
            if (c == abort_at) begin
                obs = READ_DATA;
                return;
            end
        end
        widx = (addr / 4) % DEPTH;
        if (wr) mem_model[widx] = ref_store(mem_model[widx], addr, wdata, f3);
        else    rd_model = ref_load(mem_model[widx], addr, f3);
        READ = 1'b0; WRITE = 1'b0;
        @(negedge CLK);
        check("done_busy", {31'd0, BUSY_WAIT}, 32'd0);
        check("done_rd", READ_DATA, rd_model);
        @(posedge CLK); #1;
        obs = READ_DATA;
    endtask

    initial begin
        logic [31:0] obs;
        bit [31:0]   a;
        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0;
        ADDRESS = '0; WRITE_DATA = '0; FUNC3 = '0;
        rd_model = '0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("reset_rd", READ_DATA, 32'd0);
        check("reset_busy", {31'd0, BUSY_WAIT}, 32'd0);
        @(posedge CLK); #1;

        // Fill the array so every later load has a defined reference
        for (int unsigned i = 0; i < DEPTH; i++)
            run_req(1'b0, 1'b1, i * 4, $urandom, 3'd2, -1, obs);

        // Directed: store/load word and sub-word extension
        run_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, -1, obs);
        run_req(1'b1, 1'b0, 32'h10, 32'h0, 3'd2, -1, obs);
        check("lw_10", obs, 32'hDEADBEEF);
        run_req(1'b1, 1'b0, 32'h13, 32'h0, 3'd0, -1, obs);
        check("lb_13", obs, 32'hFFFFFFDE);
        run_req(1'b1, 1'b0, 32'h13, 32'h0, 3'd4, -1, obs);
        check("lbu_13", obs, 32'h000000DE);
        run_req(1'b1, 1'b0, 32'h10, 32'h0, 3'd1, -1, obs);
        check("lh_10", obs, 32'hFFFFBEEF);
        run_req(1'b1, 1'b0, 32'h12, 32'h0, 3'd5, -1, obs);
        check("lhu_12", obs, 32'h0000DEAD);
        run_req(1'b0, 1'b1, 32'h11, 32'h5A, 3'd0, -1, obs);
        run_req(1'b1, 1'b0, 32'h10, 32'h0, 3'd2, -1, obs);
        check("sb_merge", obs, 32'hDEAD5AEF);

        // Wrap: upper address bits ignored
        run_req(1'b0, 1'b1, 32'h10 + 4 * DEPTH, 32'hCAFEF00D, 3'd2, -1, obs);
        run_req(1'b1, 1'b0, 32'h10, 32'h0, 3'd2, -1, obs);
        check("wrap_lw", obs, 32'hCAFEF00D);

        // Abort after two ACCESS cycles: nothing written, READ_DATA kept
        a = 32'(mem_model[8]);
        run_req(1'b0, 1'b1, 32'h20, 32'h12345678, 3'd2, 2, obs);
        check("abort_rd_kept", obs, 32'hCAFEF00D);
        run_req(1'b1, 1'b0, 32'h20, 32'h0, 3'd2, -1, obs);
        check("abort_no_write", obs, a);

        // Reset in the middle of a store
        READ = 1'b0; WRITE = 1'b1; ADDRESS = 32'h20; WRITE_DATA = 32'h0BADF00D; FUNC3 = 3'd2;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b0; WRITE = 1'b0;
        rd_model = '0;
        @(negedge CLK);
        check("midreset_rd", READ_DATA, 32'd0);
        check("midreset_busy", {31'd0, BUSY_WAIT}, 32'd0);
        @(posedge CLK); #1;
        run_req(1'b1, 1'b0, 32'h20, 32'h0, 3'd2, -1, obs);
        check("midreset_no_write", obs, a);

        // Both requests high: treated as a store
        run_req(1'b1, 1'b1, 32'h24, 32'h600DCAFE, 3'd2, -1, obs);
        check("both_rd_kept", obs, a);
        run_req(1'b1, 1'b0, 32'h24, 32'h0, 3'd2, -1, obs);
        check("both_stored", obs, 32'h600DCAFE);

        // Random traffic against the reference model
        for (int n = 0; n < 120; n++) begin
            bit rd, wr;
            int ab;
            int unsigned kind;
            kind = $urandom_range(0, 2);
            rd = (kind != 1);
            wr = (kind != 0);
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, LAT - 1)) : -1;
            run_req(rd, wr, $urandom, $urandom, 3'($urandom), ab, obs);
            check("rand_rd", obs, rd_model);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
